fft_seq_ctrl: RTL and testbench
===============================

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter NUMSAMPLES, default 32, meaning points per FFT frame (multiple of 4).
REQ-002 SHALL have parameter ADDRSIZE, default 8, meaning width of out_addr.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning maximum cycles allowed in LDRAM or RUNNING (2..65535).
REQ-004 SHALL have port clk  input  1  system clock; the block has one clock, and all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request one frame; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  cancel the current frame.
REQ-008 SHALL have port clr_err  input  1  leave ERROR.
REQ-009 SHALL have port init_error  input  1  RAM initializer failure.
REQ-010 SHALL have port ld_done  input  1  RAM initializer finished.
REQ-011 SHALL have port fft_done  input  1  FFT core finished.
REQ-012 SHALL have port out_ready  input  1  downstream accepts a readout beat.
REQ-013 SHALL have port ld_data  output  1  RAM initializer enable.
REQ-014 SHALL have port fft_en  output  1  FFT core enable.
REQ-015 SHALL have port out_valid  output  1  readout beat valid.
REQ-016 SHALL have port out_addr  output  ADDRSIZE  readout beat index (4 words per beat).
REQ-017 SHALL have port busy  output  1  high in every state except IDLE and ERROR.
REQ-018 SHALL have port done  output  1  one-cycle frame-complete pulse.
REQ-019 SHALL have port error  output  1  high while in ERROR.
REQ-020 SHALL have port err_code  output  2  cause code: 01 = init_error, 10 = run timeout, 11 = load timeout, 00 = none.
REQ-021 SHALL have port frame_cnt  output  16  count of completed frames, wrapping.

Function
REQ-022 SHALL drive every output from a register, with no combinational input-to-output path.
REQ-023 SHALL implement the states IDLE, LDRAM, RAMRDY, RUNNING, DRAIN, DONE and ERROR.
REQ-024 SHALL move IDLE -> LDRAM on start=1, with ld_data=1 from the first LDRAM cycle until LDRAM is exited.
REQ-025 SHALL resolve LDRAM events in this priority: init_error -> ERROR(01); else ld_done -> RAMRDY; else timeout -> ERROR(11).
REQ-026 SHALL keep RAMRDY for exactly one cycle, with ld_data=0 and fft_en=0, then enter RUNNING.
REQ-027 SHALL hold fft_en=1 throughout RUNNING, go to DRAIN on fft_done, and go to ERROR(10) on timeout.
REQ-028 SHALL, in DRAIN, drive out_valid=1 with out_addr starting at 0, incrementing it only when out_valid and out_ready are both high.
REQ-029 SHALL hold out_addr stable while out_valid=1 and out_ready=0.
REQ-030 SHALL go DRAIN -> DONE when beat NUMSAMPLES/4-1 is accepted, with out_valid=0 in the following cycle.
REQ-031 SHALL spend exactly one cycle in DONE with done=1 and frame_cnt+1 (wrapping 0xFFFF -> 0), then enter IDLE.
REQ-032 SHALL keep a 16-bit timeout counter that clears on every state entry and increments each cycle in LDRAM and RUNNING.
REQ-033 SHALL declare a timeout when the counter equals TIMEOUT-1 and the completion input for that state is low in that cycle; a completion in the same cycle wins.
REQ-034 SHALL hold error=1 and err_code in ERROR, ignore start there, and go to IDLE on clr_err, which clears err_code to 00.
REQ-035 SHALL, when abort=1 in LDRAM, RAMRDY, RUNNING or DRAIN, enter IDLE next cycle with all enables deasserted, no done pulse and frame_cnt unchanged.
REQ-036 SHALL give abort priority over all other events; abort in IDLE, DONE or ERROR has no effect.
REQ-037 SHALL ignore start outside IDLE, so that start held high re-arms only after returning to IDLE.

Reset
REQ-038 SHALL, while rst_n=0 and immediately, set state=IDLE with ld_data, fft_en, out_valid, busy, done and error at 0, and out_addr, err_code, frame_cnt and the timeout counter at 0.
REQ-039 SHALL, on reset asserted mid-frame, force the reset values immediately and not resume the frame after rst_n rises.

Verification
REQ-040 SHALL be verified by a nominal-frame scenario: start pulse, ld_done after 20 cycles, fft_done after 50 cycles, out_ready=1 -> 8 beats with out_addr 0..7, a done pulse one cycle after beat 7, frame_cnt=1.
REQ-041 SHALL be verified by a backpressure scenario: out_ready toggling 1,0,0,1 during DRAIN -> out_addr held during stalls and exactly 8 accepted beats.
REQ-042 SHALL be verified by a load-timeout scenario: TIMEOUT=16 with ld_done never asserted -> ERROR(11) after 16 LDRAM cycles, start ignored, clr_err -> IDLE with err_code=00.
REQ-043 SHALL be verified by an init_error/ld_done collision: both asserted in the same LDRAM cycle -> ERROR(01).
REQ-044 SHALL be verified by an abort scenario: abort in RUNNING -> IDLE next cycle, fft_en=0, no done, frame_cnt unchanged; a following start runs a full frame.
REQ-045 SHALL be verified by a reset scenario: rst_n pulled low during DRAIN -> all outputs 0 within the same cycle, and the controller stays in IDLE until the next start.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: sequences RAM load, FFT run and beat readout per frame.
// Ports: start/abort/clr_err cmds; ld/fft status; out_* readout; status regs.
module fft_seq_ctrl #(
  parameter int NUMSAMPLES = 32,
  parameter int ADDRSIZE   = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                clr_err,
  input  logic                init_error,
  input  logic                ld_done,
  input  logic                fft_done,
  input  logic                out_ready,
  output logic                ld_data,
  output logic                fft_en,
  output logic                out_valid,
  output logic [ADDRSIZE-1:0] out_addr,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [15:0]         frame_cnt
);

  typedef enum logic [2:0] {
    IDLE, LDRAM, RAMRDY, RUNNING, DRAIN, DONE, ERROR
  } state_t;

  localparam logic [ADDRSIZE-1:0] LAST =
    ADDRSIZE'(NUMSAMPLES / 4 - 1);
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      nxt;
  logic [15:0] tcnt;
  logic [1:0]  ecode;
  logic        tmo;
  logic        last;

  assign tmo  = (tcnt == TLAST);
  assign last = (out_addr == LAST);

  // Abort is tested first in every abortable state.
  always_comb begin
    nxt   = state;
    ecode = 2'b00;
    unique case (state)
      IDLE: if (start) nxt = LDRAM;
      LDRAM: begin
        if (abort) begin
          nxt = IDLE;
        end else if (init_error) begin
          nxt   = ERROR;
          ecode = 2'b01;
        end else if (ld_done) begin
          nxt = RAMRDY;
        end else if (tmo) begin
          nxt   = ERROR;
          ecode = 2'b11;
        end
      end
      RAMRDY: nxt = abort ? IDLE : RUNNING;
      RUNNING: begin
        if (abort) begin
          nxt = IDLE;
        end else if (fft_done) begin
          nxt = DRAIN;
        end else if (tmo) begin
          nxt   = ERROR;
          ecode = 2'b10;
        end
      end
      DRAIN: begin
        if (abort) nxt = IDLE;
        else if (out_ready && last) nxt = DONE;
      end
      DONE:  nxt = IDLE;
      ERROR: if (clr_err) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ld_data   <= 1'b0;
      fft_en    <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'b00;
      frame_cnt <= 16'd0;
      tcnt      <= 16'd0;
    end else begin
      state     <= nxt;
      ld_data   <= (nxt == LDRAM);
      fft_en    <= (nxt == RUNNING);
      out_valid <= (nxt == DRAIN);
      busy      <= !(nxt == IDLE || nxt == ERROR);
      done      <= (nxt == DONE);
      error     <= (nxt == ERROR);
      if (nxt != state)
        tcnt <= 16'd0;
      else if (state == LDRAM || state == RUNNING)
        tcnt <= tcnt + 16'd1;
      // Last beat index stays visible through DONE.
      if (nxt != DRAIN && nxt != DONE)
        out_addr <= '0;
      else if (state == DRAIN && nxt == DRAIN && out_ready)
        out_addr <= out_addr + 1'b1;
      if (nxt == ERROR && state != ERROR)
        err_code <= ecode;
      else if (nxt != ERROR)
        err_code <= 2'b00;
      if (nxt == DONE)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: directed vector table plus frame corner sequences.
// Two instances: default TIMEOUT and TIMEOUT=16 for the timeout cases.
module tb_fft_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, abort = 1'b0, clr_err = 1'b0;
  logic init_error = 1'b0, ld_done = 1'b0;
  logic fft_done = 1'b0, out_ready = 1'b0;

  logic ld_data, fft_en, out_valid, busy, done, error;
  logic [7:0] out_addr;
  logic [1:0] err_code;
  logic [15:0] frame_cnt;

  logic ld_data_b, fft_en_b, out_valid_b, busy_b, done_b, error_b;
  logic [7:0] out_addr_b;
  logic [1:0] err_code_b;
  logic [15:0] frame_cnt_b;

  always #5 clk = ~clk;

  fft_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .clr_err(clr_err), .init_error(init_error), .ld_done(ld_done),
    .fft_done(fft_done), .out_ready(out_ready), .ld_data(ld_data),
    .fft_en(fft_en), .out_valid(out_valid), .out_addr(out_addr),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  fft_seq_ctrl #(.TIMEOUT(16)) u_t16 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .clr_err(clr_err), .init_error(init_error), .ld_done(ld_done),
    .fft_done(fft_done), .out_ready(out_ready), .ld_data(ld_data_b),
    .fft_en(fft_en_b), .out_valid(out_valid_b), .out_addr(out_addr_b),
    .busy(busy_b), .done(done_b), .error(error_b),
    .err_code(err_code_b), .frame_cnt(frame_cnt_b)
  );

  function automatic logic [31:0] pk(
    input logic ld, input logic fe, input logic ov, input logic bz,
    input logic dn, input logic er, input logic [1:0] ec,
    input logic [7:0] ad, input logic [15:0] fc);
    return {ld, fe, ov, bz, dn, er, ec, ad, fc};
  endfunction

  function automatic logic [31:0] e_id(input logic [15:0] fc);
    return pk(0, 0, 0, 0, 0, 0, 2'b00, 8'd0, fc);
  endfunction
  function automatic logic [31:0] e_ld(input logic [15:0] fc);
    return pk(1, 0, 0, 1, 0, 0, 2'b00, 8'd0, fc);
  endfunction
  function automatic logic [31:0] e_rr(input logic [15:0] fc);
    return pk(0, 0, 0, 1, 0, 0, 2'b00, 8'd0, fc);
  endfunction
  function automatic logic [31:0] e_rn(input logic [15:0] fc);
    return pk(0, 1, 0, 1, 0, 0, 2'b00, 8'd0, fc);
  endfunction
  function automatic logic [31:0] e_dr(input logic [7:0] a,
                                       input logic [15:0] fc);
    return pk(0, 0, 1, 1, 0, 0, 2'b00, a, fc);
  endfunction
  function automatic logic [31:0] e_dn(input logic [7:0] a,
                                       input logic [15:0] fc);
    return pk(0, 0, 0, 1, 1, 0, 2'b00, a, fc);
  endfunction
  function automatic logic [31:0] e_er(input logic [1:0] c,
                                       input logic [15:0] fc);
    return pk(0, 0, 0, 0, 0, 1, c, 8'd0, fc);
  endfunction

  logic [31:0] obs, obs_b;
  assign obs = pk(ld_data, fft_en, out_valid, busy, done, error,
                  err_code, out_addr, frame_cnt);
  assign obs_b = pk(ld_data_b, fft_en_b, out_valid_b, busy_b, done_b,
                    error_b, err_code_b, out_addr_b, frame_cnt_b);

  // {start, abort, clr_err, init_error, ld_done, fft_done, out_ready}
  localparam logic [6:0] I_NO  = 7'b0000000;
  localparam logic [6:0] I_ST  = 7'b1000000;
  localparam logic [6:0] I_AB  = 7'b0100000;
  localparam logic [6:0] I_CLR = 7'b0010000;
  localparam logic [6:0] I_IE  = 7'b0001000;
  localparam logic [6:0] I_LDD = 7'b0000100;
  localparam logic [6:0] I_FD  = 7'b0000010;
  localparam logic [6:0] I_RDY = 7'b0000001;

  typedef struct {
    logic [6:0]  in;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [23];

  int nvec = 0;
  int nfail = 0;
  logic [15:0] exp_fc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] v);
    {start, abort, clr_err, init_error, ld_done, fft_done, out_ready} = v;
  endtask

  task automatic put(input int i, input logic [6:0] v,
                     input logic [31:0] e);
    tbl[i].in  = v;
    tbl[i].exp = e;
  endtask

  // Abort clears any busy state, clr_err clears ERROR.
  task automatic idle_both();
    drive(I_AB | I_CLR);
    step();
    drive(I_NO);
  endtask

  task automatic frame_quick(input string nm);
    drive(I_ST);
    step();
    chk({nm, "_ld"}, obs, e_ld(exp_fc));
    drive(I_LDD);
    step();
    chk({nm, "_rr"}, obs, e_rr(exp_fc));
    drive(I_NO);
    step();
    chk({nm, "_run"}, obs, e_rn(exp_fc));
    drive(I_FD);
    step();
    drive(I_RDY);
    for (int b = 0; b < 8; b++) begin
      chk({nm, "_beat"}, obs, e_dr(8'(b), exp_fc));
      step();
    end
    chk({nm, "_done"}, obs, e_dn(8'd7, exp_fc + 16'd1));
    exp_fc = exp_fc + 16'd1;
    drive(I_NO);
    step();
    chk({nm, "_idle"}, obs, e_id(exp_fc));
  endtask

  initial begin
    int acc;
    logic [7:0] ea;
    logic p;

    #2 rst_n = 1'b0;
    #1;
    chk("reset", obs, 32'd0);
    chk("reset_b", obs_b, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    exp_fc = 16'd0;

    // Nominal frame: ld_done in LDRAM cycle 20, fft_done in RUNNING cycle 50.
    drive(I_ST);
    step();
    chk("nom_ld", obs, e_ld(exp_fc));
    drive(I_NO);
    for (int i = 1; i < 20; i++) begin
      step();
      chk("nom_ld", obs, e_ld(exp_fc));
    end
    drive(I_LDD);
    step();
    chk("nom_ramrdy", obs, e_rr(exp_fc));
    drive(I_NO);
    step();
    chk("nom_run", obs, e_rn(exp_fc));
    for (int i = 1; i < 50; i++) begin
      step();
      chk("nom_run", obs, e_rn(exp_fc));
    end
    drive(I_FD);
    step();
    drive(I_RDY);
    for (int b = 0; b < 8; b++) begin
      chk("nom_beat", obs, e_dr(8'(b), exp_fc));
      step();
    end
    chk("nom_done", obs, e_dn(8'd7, 16'd1));
    drive(I_NO);
    step();
    chk("nom_idle", obs, e_id(16'd1));

    put(0,  I_ST,          e_ld(16'd1));
    put(1,  I_LDD,         e_rr(16'd1));
    put(2,  I_NO,          e_rn(16'd1));
    put(3,  I_FD,          e_dr(8'd0, 16'd1));
    put(4,  I_RDY,         e_dr(8'd1, 16'd1));
    put(5,  I_NO,          e_dr(8'd1, 16'd1));
    put(6,  I_RDY,         e_dr(8'd2, 16'd1));
    put(7,  I_RDY,         e_dr(8'd3, 16'd1));
    put(8,  I_RDY,         e_dr(8'd4, 16'd1));
    put(9,  I_RDY,         e_dr(8'd5, 16'd1));
    put(10, I_RDY,         e_dr(8'd6, 16'd1));
    put(11, I_RDY,         e_dr(8'd7, 16'd1));
    put(12, I_RDY,         e_dn(8'd7, 16'd2));
    put(13, I_ST,          e_id(16'd2));
    put(14, I_ST,          e_ld(16'd2));
    put(15, I_AB | I_LDD,  e_id(16'd2));
    put(16, I_AB,          e_id(16'd2));
    put(17, I_ST,          e_ld(16'd2));
    put(18, I_IE | I_LDD,  e_er(2'b01, 16'd2));
    put(19, I_ST,          e_er(2'b01, 16'd2));
    put(20, I_AB,          e_er(2'b01, 16'd2));
    put(21, I_CLR,         e_id(16'd2));
    put(22, I_FD | I_RDY,  e_id(16'd2));

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].in);
      step();
      chk($sformatf("vec%0d", i), obs, tbl[i].exp);
    end
    drive(I_NO);
    idle_both();
    exp_fc = 16'd2;

    // Backpressure: out_ready pattern 1,0,0,1 during DRAIN.
    drive(I_ST);
    step();
    drive(I_LDD);
    step();
    drive(I_NO);
    step();
    drive(I_FD);
    step();
    acc = 0;
    ea = 8'd0;
    for (int k = 0; k < 64 && acc < 8; k++) begin
      p = (k % 4 == 0) || (k % 4 == 3);
      drive(p ? I_RDY : I_NO);
      chk("bp_beat", obs, e_dr(ea, exp_fc));
      step();
      if (p) begin
        acc++;
        if (acc < 8) ea = ea + 8'd1;
      end
    end
    chk("bp_count", 32'(acc), 32'd8);
    chk("bp_done", obs, e_dn(8'd7, exp_fc + 16'd1));
    exp_fc = exp_fc + 16'd1;
    drive(I_NO);
    step();
    chk("bp_idle", obs, e_id(exp_fc));

    // Abort in RUNNING, then a full frame.
    drive(I_ST);
    step();
    drive(I_LDD);
    step();
    drive(I_NO);
    step();
    step();
    chk("ab_run", obs, e_rn(exp_fc));
    drive(I_AB);
    step();
    chk("ab_idle", obs, e_id(exp_fc));
    drive(I_NO);
    step();
    chk("ab_nodone", obs, e_id(exp_fc));
    frame_quick("ab_frame");

    // Reset during DRAIN.
    drive(I_ST);
    step();
    drive(I_LDD);
    step();
    drive(I_NO);
    step();
    drive(I_FD);
    step();
    drive(I_RDY);
    step();
    step();
    chk("rst_pre", obs, e_dr(8'd2, exp_fc));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", obs, 32'd0);
    chk("rst_async_b", obs_b, 32'd0);
    step();
    rst_n = 1'b1;
    exp_fc = 16'd0;
    drive(I_LDD | I_FD | I_RDY);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_stay", obs, e_id(exp_fc));
    end
    drive(I_ST);
    step();
    chk("rst_restart", obs, e_ld(exp_fc));
    idle_both();

    // Load timeout on the TIMEOUT=16 instance.
    drive(I_ST);
    step();
    drive(I_NO);
    chk("lt_ld", obs_b, e_ld(16'd0));
    for (int i = 1; i < 16; i++) begin
      step();
      chk("lt_ld", obs_b, e_ld(16'd0));
    end
    step();
    chk("lt_err", obs_b, e_er(2'b11, 16'd0));
    drive(I_ST);
    step();
    chk("lt_start_ign", obs_b, e_er(2'b11, 16'd0));
    drive(I_CLR);
    step();
    chk("lt_clr", obs_b, e_id(16'd0));
    drive(I_NO);
    idle_both();

    // ld_done on the timeout cycle wins.
    drive(I_ST);
    step();
    drive(I_NO);
    for (int i = 1; i < 16; i++) step();
    chk("tw_ld", obs_b, e_ld(16'd0));
    drive(I_LDD);
    step();
    chk("tw_rr", obs_b, e_rr(16'd0));
    drive(I_NO);
    idle_both();

    // Run timeout.
    drive(I_ST);
    step();
    drive(I_LDD);
    step();
    drive(I_NO);
    step();
    for (int i = 1; i < 16; i++) begin
      step();
      chk("rt_run", obs_b, e_rn(16'd0));
    end
    step();
    chk("rt_err", obs_b, e_er(2'b10, 16'd0));
    drive(I_CLR);
    step();
    chk("rt_clr", obs_b, e_id(16'd0));
    drive(I_NO);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
